extbus_memory: RTL and testbench
================================

// Module: extbus_memory
// PURPOSE
//  Memory-side responder for the external bus driven by the micro-BESM bus arbiter.
//  Latches the address on the address strobe, then services one read or one write
//  after a programmable number of wait states. Completes each access with a
//  four-phase ready handshake. Instantiated in the testbench/top as main memory.
// PARAMETERS
//  DATA_W   64    word width, bits
//  ADDR_W   15    address width, bits
//  DEPTH    32768 implemented words; addresses >= DEPTH are out of range
//  WAIT     2     wait states between access start and o_ready (0..15)
// PORTS
//  clk      in   1       clock; all logic on posedge
//  reset    in   1       synchronous, active-high reset
//  i_astb   in   1       address strobe; i_addr valid when high
//  i_addr   in   ADDR_W  word address
//  i_rd     in   1       read request; held until o_ready seen
//  i_wr     in   1       write request; held until o_ready seen
//  i_data   in   DATA_W  write data; valid while i_wr high
//  o_data   out  DATA_W  read data; valid while o_ready high after a read
//  o_ready  out  1       access complete; held until i_rd/i_wr both low
//  o_err    out  1       one-cycle pulse: protocol error or out-of-range address
// BEHAVIOUR
//  - Reset values: o_data=0, o_ready=0, o_err=0, state=IDLE, addr_valid=0.
//    Reset does NOT clear the memory array. Reset mid-access aborts it:
//    no write is committed, and o_ready drops on the next cycle.
//  - States: IDLE, WAIT, DONE.
//  - IDLE: i_astb=1 -> latch i_addr, set addr_valid. A new i_astb overwrites the
//    address (last strobe wins).
//    i_rd^i_wr with addr_valid=1 -> start the access:
//    - load the wait counter with WAIT;
//    - go to WAIT, or straight to DONE if WAIT==0.
//  - WAIT: decrement the counter each cycle; at 0 go to DONE. If i_rd/i_wr drops
//    early, return to IDLE with no access, no o_ready, and o_err pulse.
//  - Entering DONE (same edge that sets o_ready):
//    - read: o_data <= mem[addr];
//    - write: mem[addr] <= i_data, sampled at that edge.
//    - Then clear addr_valid; every access needs a fresh strobe.
//  - DONE: o_ready=1 held. When i_rd=0 and i_wr=0 -> o_ready=0, o_data=0, go to IDLE.
//  - Latency: the strobe cycle, then the request cycle. o_ready rises WAIT+1 cycles
//    after the first cycle with i_rd/i_wr high in IDLE.
//  - Out of range (addr >= DEPTH):
//    - the handshake completes normally;
//    - a read returns all zeros; a write is dropped;
//    - o_err pulses in the cycle o_ready rises.
//  - Errors in IDLE pulse o_err for one cycle, stay in IDLE, and assert no o_ready:
//    - i_rd & i_wr both high;
//    - i_rd or i_wr with addr_valid=0.
//    The error is reported once per request: o_err re-arms only after i_rd and i_wr
//    both drop.
//  - i_astb together with i_rd/i_wr in the same cycle: the new address is latched
//    and used for that access.
//  - i_astb outside IDLE is ignored.
// TESTING
//  1. WAIT=2: astb addr=5, wr data=64'h0123_4567_89AB_CDEF -> o_ready 3 cycles later;
//     then astb 5, rd -> o_data=64'h0123_4567_89AB_CDEF with o_ready.
//  2. WAIT=0: astb addr=7 + rd in same cycle -> o_ready next cycle, o_data=mem[7];
//     dropping rd -> o_ready=0, o_data=0 next cycle.
//  3. rd without prior astb -> o_err one pulse, o_ready stays 0, no state change;
//     rd&wr together after astb -> o_err, no write committed.
//  4. astb addr=DEPTH, wr 64'hFFFF -> o_ready+o_err; then rd of DEPTH -> o_data=0,
//     and mem[0] is unchanged.
//  5. Write started, reset asserted during WAIT -> outputs 0 next cycle, target word
//     keeps its old value; other words preserved across reset.
//  6. Back-to-back: 4 writes then 4 reads to addrs 0..3, each needing a fresh astb;
//     a second rd without astb -> o_err.

Source files
------------

// File: rtl/extbus_memory.sv
// Memory-side responder for the external bus: latches an address on the strobe,
// services one read or write after WAIT wait states, then holds o_ready until released.
module extbus_memory #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_astb,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ready,
  output logic              o_err,
  output logic [1:0]        o_dbg_state
);

  // Handshake: the requester raises exactly one of i_rd/i_wr and holds it until
  // o_ready is seen; o_ready then stays high until both requests are low, and
  // drops (with o_data cleared) on the following edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              av_q, av_d;
  logic              wr_q, wr_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic              req, both, enter_done, op_wr, in_range, mem_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    av_d       = av_q;
    wr_d       = wr_q;
    armed_d    = armed_q;
    data_d     = data_q;
    ready_d    = ready_q;
    err_d      = 1'b0;
    enter_done = 1'b0;
    mem_we     = 1'b0;
    req        = i_rd | i_wr;
    both       = i_rd & i_wr;
    // A strobe in the same cycle as the request supplies the address for it.
    acc_addr   = (state_q == S_IDLE && i_astb) ? i_addr : addr_q;
    in_range   = {1'b0, acc_addr} < DEPTH_L;
    idx        = acc_addr[IDX_W-1:0];
    op_wr      = (state_q == S_IDLE) ? i_wr : wr_q;

    case (state_q)
      S_IDLE: begin
        if (i_astb) begin
          addr_d = i_addr;
          av_d   = 1'b1;
        end
        if (both || (req && !(i_astb || av_q))) begin
          err_d   = armed_q;
          armed_d = 1'b0;
        end else if (req) begin
          wr_d  = i_wr;
          cnt_d = WAIT_L;
          if (WAIT_L == 4'd0) enter_done = 1'b1;
          else                state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wr_q ? !i_wr : !i_rd) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (!req) begin
          ready_d = 1'b0;
          data_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!req) armed_d = 1'b1;

    if (enter_done) begin
      state_d = S_DONE;
      ready_d = 1'b1;
      av_d    = 1'b0;
      if (in_range) begin
        if (op_wr) mem_we = 1'b1;
        else       data_d = mem[idx];
      end else begin
        err_d = 1'b1;
        if (!op_wr) data_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      av_q    <= 1'b0;
      wr_q    <= 1'b0;
      armed_q <= 1'b1;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      av_q    <= av_d;
      wr_q    <= wr_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // The array has no reset; only the commit is suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx] <= i_data;
  end

  assign o_data      = data_q;
  assign o_ready     = ready_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_extbus_memory.sv
// Bench for extbus_memory: two instances (WAIT=2 and WAIT=0) share one stimulus
// stream and are each checked every cycle against a countdown-based access model.
module tb_extbus_memory;

  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int DEPTH = 100;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          astb  = 1'b0;
  logic          rd    = 1'b0;
  logic          wr    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] data2, data0;
  logic          ready2, ready0, err2, err0;
  logic [1:0]    dbg2, dbg0;

  extbus_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(2)) u_w2 (
    .clk(clk), .reset(reset), .i_astb(astb), .i_addr(addr), .i_rd(rd), .i_wr(wr),
    .i_data(wdata), .o_data(data2), .o_ready(ready2), .o_err(err2), .o_dbg_state(dbg2));

  extbus_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .i_astb(astb), .i_addr(addr), .i_rd(rd), .i_wr(wr),
    .i_data(wdata), .o_data(data0), .o_ready(ready0), .o_err(err0), .o_dbg_state(dbg0));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] init_val(input int a);
    logic [63:0] base;
    base = 64'hC0DE_0000_0000_0000;
    return base | 64'(a);
  endfunction

  // ---------------- behavioural model (index 0: WAIT=2, index 1: WAIT=0) ----------------
  int            m_wait [2] = '{2, 0};
  logic [63:0]   m_mem  [2][DEPTH];
  logic [AW-1:0] m_addr [2];
  bit            m_av   [2];
  bit            m_armed[2];
  bit            m_hold [2];
  bit            m_iswr [2];
  int            m_left [2];
  logic [63:0]   e_data [2];
  bit            e_ready[2];
  bit            e_err  [2];

  task automatic finish_access(input int k);
    e_ready[k] = 1'b1;
    m_hold[k]  = 1'b1;
    m_left[k]  = -1;
    m_av[k]    = 1'b0;
    if (int'(m_addr[k]) < DEPTH) begin
      if (m_iswr[k]) m_mem[k][m_addr[k]] = wdata;
      else           e_data[k] = m_mem[k][m_addr[k]];
    end else begin
      e_err[k] = 1'b1;
      if (!m_iswr[k]) e_data[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    e_err[k] = 1'b0;
    if (reset) begin
      e_ready[k] = 1'b0; e_data[k] = '0; m_av[k] = 1'b0;
      m_armed[k] = 1'b1; m_left[k] = -1; m_hold[k] = 1'b0;
      return;
    end
    if (m_hold[k]) begin
      if (!rd && !wr) begin
        m_hold[k] = 1'b0; e_ready[k] = 1'b0; e_data[k] = '0;
      end
    end else if (m_left[k] > 0) begin
      if (m_iswr[k] ? !wr : !rd) begin
        m_left[k] = -1; e_err[k] = 1'b1;
      end else begin
        m_left[k]--;
        if (m_left[k] == 0) finish_access(k);
      end
    end else begin
      if (astb) begin m_addr[k] = addr; m_av[k] = 1'b1; end
      if ((rd && wr) || ((rd || wr) && !m_av[k])) begin
        e_err[k]   = m_armed[k];
        m_armed[k] = 1'b0;
      end else if (rd || wr) begin
        m_iswr[k] = wr;
        m_left[k] = m_wait[k];
        if (m_left[k] == 0) finish_access(k);
      end
    end
    if (!rd && !wr) m_armed[k] = 1'b1;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    cyc++;
  end

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("w2_ready", 64'(ready2), 64'(e_ready[0]));
      check("w2_err",   64'(err2),   64'(e_err[0]));
      check("w2_data",  data2,       e_data[0]);
      check("w0_ready", 64'(ready0), 64'(e_ready[1]));
      check("w0_err",   64'(err0),   64'(e_err[1]));
      check("w0_data",  data0,       e_data[1]);
    end
  end

  // ---------------- driver ----------------
  int          r_lat2, r_lat0;
  logic [63:0] r_dat2, r_dat0;
  bit          r_erise2, r_erise0, r_err2, r_err0;

  // strobe: 0 none, 1 separate cycle before the request, 2 same cycle as the request
  task automatic access(input int strobe, input logic [AW-1:0] a, input bit r, input bit w,
                        input logic [63:0] d, input int hold, input bit jitter);
    r_lat2 = 0; r_lat0 = 0; r_dat2 = '0; r_dat0 = '0;
    r_erise2 = 0; r_erise0 = 0; r_err2 = 0; r_err0 = 0;
    if (strobe == 1) begin
      astb = 1'b1; addr = a;
      @(negedge clk);
      astb = 1'b0;
    end
    if (strobe == 2) begin astb = 1'b1; addr = a; end
    rd = r; wr = w; wdata = d;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      astb = 1'b0;
      if (ready2 && r_lat2 == 0) begin r_lat2 = i; r_dat2 = data2; r_erise2 = err2; end
      if (ready0 && r_lat0 == 0) begin r_lat0 = i; r_dat0 = data0; r_erise0 = err0; end
      r_err2 |= err2;
      r_err0 |= err0;
      if (jitter) begin
        wdata = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin astb = 1'b1; addr = AW'($urandom_range(0, 109)); end
      end
    end
    rd = 1'b0; wr = 1'b0; astb = 1'b0;
    @(negedge clk);
    r_err2 |= err2;
    r_err0 |= err0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready2", 64'(ready2), 64'd0);
    check("rst_data2",  data2,       64'd0);
    check("rst_err2",   64'(err2),   64'd0);
    check("rst_state2", 64'(dbg2),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) access(1, AW'(a), 0, 1, init_val(a), 4, 0);

    // write then read back address 5
    access(1, 8'd5, 0, 1, 64'h0123_4567_89AB_CDEF, 5, 0);
    check("t1_wr_lat2", 64'(r_lat2), 64'd3);
    check("t1_wr_lat0", 64'(r_lat0), 64'd1);
    access(1, 8'd5, 1, 0, 64'd0, 5, 0);
    check("t1_rd_lat2", 64'(r_lat2), 64'd3);
    check("t1_rd_dat2", r_dat2, 64'h0123_4567_89AB_CDEF);
    check("t1_rd_dat0", r_dat0, 64'h0123_4567_89AB_CDEF);

    // strobe and read in the same cycle
    access(2, 8'd7, 1, 0, 64'd0, 3, 0);
    check("t2_lat0", 64'(r_lat0), 64'd1);
    check("t2_dat0", r_dat0, 64'hC0DE_0000_0000_0007);
    check("t2_dat2", r_dat2, 64'hC0DE_0000_0000_0007);
    check("t2_rel_ready0", 64'(ready0), 64'd0);
    check("t2_rel_data0",  data0,       64'd0);

    // protocol errors
    access(0, 8'd0, 1, 0, 64'd0, 3, 0);
    check("t3_noastb_err2",   64'(r_err2), 64'd1);
    check("t3_noastb_ready2", 64'(r_lat2), 64'd0);
    access(1, 8'd11, 1, 1, 64'hDEAD, 3, 0);
    check("t3_both_err2",   64'(r_err2), 64'd1);
    check("t3_both_ready0", 64'(r_lat0), 64'd0);
    access(1, 8'd11, 1, 0, 64'd0, 5, 0);
    check("t3_both_nowrite", r_dat2, 64'hC0DE_0000_0000_000B);

    // out of range
    access(1, 8'd100, 0, 1, 64'hFFFF, 5, 0);
    check("t4_oor_lat2",  64'(r_lat2),   64'd3);
    check("t4_oor_erise", 64'(r_erise2), 64'd1);
    check("t4_oor_erise0", 64'(r_erise0), 64'd1);
    access(1, 8'd100, 1, 0, 64'd0, 5, 0);
    check("t4_oor_rd_dat", r_dat2, 64'd0);
    access(1, 8'd0, 1, 0, 64'd0, 5, 0);
    check("t4_mem0_kept", r_dat2, 64'hC0DE_0000_0000_0000);

    // reset while the WAIT=2 instance is waiting
    astb = 1'b1; addr = 8'd9;
    @(negedge clk);
    astb = 1'b0; wr = 1'b1; wdata = 64'hBAD;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_ready2", 64'(ready2), 64'd0);
    check("t5_ready0", 64'(ready0), 64'd0);
    wr = 1'b0; reset = 1'b0;
    @(negedge clk);
    access(1, 8'd9, 1, 0, 64'd0, 5, 0);
    check("t5_target_kept2", r_dat2, 64'hC0DE_0000_0000_0009);
    check("t5_target_done0", r_dat0, 64'hBAD);
    access(1, 8'd5, 1, 0, 64'd0, 5, 0);
    check("t5_other_kept2", r_dat2, 64'h0123_4567_89AB_CDEF);

    // back-to-back accesses, each with its own strobe
    for (int a = 0; a < 4; a++) access(1, AW'(a), 0, 1, 64'h6000 + 64'(a), 4, 0);
    for (int a = 0; a < 4; a++) begin
      access(1, AW'(a), 1, 0, 64'd0, 4, 0);
      check("t6_rd_dat2", r_dat2, 64'h6000 + 64'(a));
    end
    access(0, 8'd0, 1, 0, 64'd0, 3, 0);
    check("t6_restrobe_err", 64'(r_err2), 64'd1);

    // request dropped during the wait states
    access(1, 8'd20, 0, 1, 64'h77, 1, 0);
    check("abort_err2",   64'(r_err2), 64'd1);
    check("abort_ready2", 64'(r_lat2), 64'd0);
    access(1, 8'd20, 1, 0, 64'd0, 5, 0);
    check("abort_nowrite2", r_dat2, 64'hC0DE_0000_0000_0014);
    check("abort_write0",   r_dat0, 64'h77);

    // randomized traffic, checked by the per-cycle compare
    for (int n = 0; n < 200; n++) begin
      int  strobe, op, hold;
      bit  r, w;
      strobe = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2));
      op     = $urandom_range(0, 9);
      r      = (op == 0) || (op < 5);
      w      = (op == 0) || (op >= 5);
      hold   = ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(3, 6));
      access(strobe, AW'($urandom_range(0, 109)), r, w, {$urandom, $urandom}, hold, 1);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
